// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Responder end of the processor data-memory interface. Services MemRead/MemWrite
//   requests against an internal word array. It inserts WAIT_STATES wait cycles,
//   signals completion with a one-cycle mem_ready pulse, and flags illegal requests
//   with mem_error.
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   MemRead     read request level, held by the requester until mem_ready
//   MemWrite    write request level, held by the requester until mem_ready
//   address     byte address; word index = address[AW+1:2]
//   write_data  store data, sampled when the request is accepted
//   read_data   load data, valid from mem_ready, held until the next good read
//   mem_ready   one-cycle completion pulse
//   mem_error   qualifies mem_ready: the request was illegal and no access was made
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        mem_ready,
  output logic        mem_error
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WaitLoad = 4'(WAIT_STATES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic          we_q;
  logic          err_q;
  logic [31:0]   rdata_q;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          req;
  logic          req_err;
  logic [AW-1:0] req_idx;
  logic          accept;
  logic          enter_done;
  logic          rd_fire;
  logic [AW-1:0] rd_idx;

  assign req     = MemRead | MemWrite;
  assign req_idx = address[AW+1:2];
  assign req_err = (MemRead & MemWrite) | (address[1:0] != 2'b00) |
                   ((address >> (AW + 2)) != 32'd0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    enter_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d    = S_DONE;
            enter_done = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WaitLoad;
          end
        end
      end
      S_WAIT: begin
        // Requester withdrawing the request aborts it with no access and no pulse.
        if (!req) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd1) begin
          state_d    = S_DONE;
          enter_done = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: state_d = S_HOLD;
      S_HOLD: begin
        // Wait for the request to drop so a held request is serviced only once.
        if (!req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reads are loaded on the edge entering DONE so the data is visible alongside
  // mem_ready. With zero wait states that edge is the acceptance edge, so the live
  // request is used instead of the latched copy.
  always_comb begin
    if (state_q == S_IDLE) begin
      rd_idx  = req_idx;
      rd_fire = enter_done & MemRead & ~req_err;
    end else begin
      rd_idx  = idx_q;
      rd_fire = enter_done & ~we_q & ~err_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q   <= req_idx;
        wdata_q <= write_data;
        we_q    <= MemWrite;
        err_q   <= req_err;
      end
      if (rd_fire) rdata_q <= mem[rd_idx];
    end
  end

  // Array is not reset; a reset during WAIT/DONE pulls state out of DONE first,
  // so no partial write can occur.
  always_ff @(posedge clk) begin
    if (state_q == S_DONE && we_q && !err_q) mem[idx_q] <= wdata_q;
  end

  assign read_data = rdata_q;
  assign mem_ready = (state_q == S_DONE);
  assign mem_error = mem_ready & err_q;

endmodule
